// File: rtl/ft245_sync_pkg.sv
// Shared definitions for the FT245 synchronous FIFO bridge: bus FSM states and
// the read headroom that covers the one-cycle lag of the registered RD# strobe.
package ft245_sync_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_OE = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        TURN    = 3'd4
    } ft_state_e;

    localparam int RD_HEADROOM = 2;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO with occupancy count and a
// synchronous flush that also discards a write presented in the same cycle.
module byte_fifo #(
    parameter int FIFO_AW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [FIFO_AW:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               wr_ok;
    logic               rd_ok;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Storage is left unreset so it can map onto RAM; the head is read
    // combinationally so the current byte is always visible (fall-through).
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ft245_sync_fifo_core.sv
// FT245 synchronous-FIFO bus bridge: host-to-FPGA and FPGA-to-host byte FIFOs
// plus the bus FSM. Define FT245_SIWU_FLUSH_EN to pulse SIWU after a drained write burst.
module ft245_sync_fifo_core
    import ft245_sync_pkg::*;
#(
    parameter int FIFO_AW = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_fifo_rst,
    input  logic       in_fifo_rd,
    output logic       in_fifo_empty,
    output logic [7:0] in_fifo_data,
    input  logic       out_fifo_wr,
    output logic       out_fifo_full,
    input  logic [7:0] out_fifo_data,
    inout  wire  [7:0] ftdi_data,
    input  logic       ftdi_txe_n,
    input  logic       ftdi_rde_n,
    output logic       ftdi_wr_n,
    output logic       ftdi_rd_n,
    output logic       ftdi_oe_n,
    output logic       ftdi_siwu,
    input  logic       ftdi_suspend_n
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_READ_OE = READ_OE;
    localparam logic [2:0] ST_READ    = READ;
    localparam logic [2:0] ST_WRITE   = WRITE;
    localparam logic [2:0] ST_TURN    = TURN;

    localparam logic [FIFO_AW:0] DEPTH_C    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] HEADROOM_C = (FIFO_AW + 1)'(RD_HEADROOM);

    logic [2:0]       state_reg, state_next;
    logic             rd_n_reg, rd_n_next;
    logic             wr_n_reg, wr_n_next;
    logic             oe_n_reg, oe_n_next;
    logic [7:0]       in_data_reg;

    logic             in_wr, in_pop, in_empty, in_full;
    logic [7:0]       in_head;
    logic [FIFO_AW:0] in_count, in_free, in_free_after;

    logic             out_pop, out_empty, out_full;
    logic [7:0]       out_head;
    logic [FIFO_AW:0] out_count, out_remaining;

    // A bus byte is transferred on any edge where both RD# and RXF# are low.
    assign in_wr  = (state_reg == ST_READ) & ~rd_n_reg & ~ftdi_rde_n & ~in_full;
    assign in_pop = in_fifo_rd & ~in_empty;

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (in_fifo_rst),
        .wr_en   (in_wr),
        .wr_data (ftdi_data),
        .rd_en   (in_fifo_rd),
        .rd_data (in_head),
        .count   (in_count),
        .empty   (in_empty),
        .full    (in_full)
    );

    assign out_pop = (state_reg == ST_WRITE) & ~wr_n_reg & ~ftdi_txe_n;

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .wr_en   (out_fifo_wr),
        .wr_data (out_fifo_data),
        .rd_en   (out_pop),
        .rd_data (out_head),
        .count   (out_count),
        .empty   (out_empty),
        .full    (out_full)
    );

    assign in_free       = DEPTH_C - in_count;
    assign in_free_after = in_free - {{FIFO_AW{1'b0}}, in_wr};
    assign out_remaining = out_count - {{FIFO_AW{1'b0}}, out_pop};

`ifdef FT245_SIWU_FLUSH_EN
    logic siwu_reg, siwu_next;
`endif

    always_comb begin
        state_next = state_reg;
        rd_n_next  = rd_n_reg;
        wr_n_next  = wr_n_reg;
        oe_n_next  = oe_n_reg;
`ifdef FT245_SIWU_FLUSH_EN
        siwu_next  = 1'b1;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!ftdi_suspend_n) begin
                    state_next = ST_IDLE;
                end else if (!ftdi_rde_n && (in_free > HEADROOM_C)) begin
                    state_next = ST_READ_OE;
                    oe_n_next  = 1'b0;
                end else if (!ftdi_txe_n && !out_empty) begin
                    state_next = ST_WRITE;
                end
            end
            ST_READ_OE: begin
                rd_n_next  = 1'b0;
                state_next = ST_READ;
            end
            ST_READ: begin
                // Stop while two slots remain: RD# is registered, so one more
                // byte can still land after the decision edge.
                if (ftdi_rde_n || (in_free_after <= HEADROOM_C) ||
                    in_fifo_rst || !ftdi_suspend_n) begin
                    rd_n_next  = 1'b1;
                    oe_n_next  = 1'b1;
                    state_next = ST_TURN;
                end
            end
            ST_WRITE: begin
                if ((out_remaining == '0) || ftdi_txe_n || !ftdi_suspend_n) begin
                    wr_n_next  = 1'b1;
                    state_next = ST_TURN;
`ifdef FT245_SIWU_FLUSH_EN
                    siwu_next  = (out_remaining != '0);
`endif
                end else begin
                    wr_n_next = 1'b0;
                end
            end
            ST_TURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                rd_n_next  = 1'b1;
                wr_n_next  = 1'b1;
                oe_n_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rd_n_reg    <= 1'b1;
            wr_n_reg    <= 1'b1;
            oe_n_reg    <= 1'b1;
            in_data_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            rd_n_reg  <= rd_n_next;
            wr_n_reg  <= wr_n_next;
            oe_n_reg  <= oe_n_next;
            if (in_pop) begin
                in_data_reg <= in_head;
            end
        end
    end

`ifdef FT245_SIWU_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            siwu_reg <= 1'b1;
        end else begin
            siwu_reg <= siwu_next;
        end
    end
    assign ftdi_siwu = siwu_reg;
`else
    assign ftdi_siwu = 1'b1;
`endif

    // The bus is only driven in WRITE, which is never entered with OE# low.
    assign ftdi_data     = (state_reg == ST_WRITE) ? out_head : 8'bzzzz_zzzz;
    assign ftdi_wr_n     = wr_n_reg;
    assign ftdi_rd_n     = rd_n_reg;
    assign ftdi_oe_n     = oe_n_reg;
    assign in_fifo_data  = in_data_reg;
    assign in_fifo_empty = in_empty;
    assign out_fifo_full = out_full;

endmodule

// File: tb/tb_ft245_sync_fifo_core.sv
// Directed bench for ft245_sync_fifo_core with a behavioural FT245 chip model and
// scoreboards for both directions.
module tb_ft245_sync_fifo_core;
    import ft245_sync_pkg::*;

`ifdef FT245_SIWU_FLUSH_EN
    localparam int SIWU_PULSE = 1;
`else
    localparam int SIWU_PULSE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_fifo_rst = 1'b0;
    logic       in_fifo_rd = 1'b0;
    logic       in_fifo_empty;
    logic [7:0] in_fifo_data;
    logic       out_fifo_wr = 1'b0;
    logic       out_fifo_full;
    logic [7:0] out_fifo_data = 8'h00;
    wire  [7:0] ftdi_data;
    logic       txe_n = 1'b1;
    logic       rde_n = 1'b1;
    logic       wr_n, rd_n, oe_n, siwu;
    logic       suspend_n = 1'b1;
    logic [7:0] bus_drv = 8'h00;

    always #5 clk = ~clk;

    assign ftdi_data = (oe_n == 1'b0) ? bus_drv : 8'bzzzz_zzzz;

    ft245_sync_fifo_core #(.FIFO_AW(9)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_fifo_rst    (in_fifo_rst),
        .in_fifo_rd     (in_fifo_rd),
        .in_fifo_empty  (in_fifo_empty),
        .in_fifo_data   (in_fifo_data),
        .out_fifo_wr    (out_fifo_wr),
        .out_fifo_full  (out_fifo_full),
        .out_fifo_data  (out_fifo_data),
        .ftdi_data      (ftdi_data),
        .ftdi_txe_n     (txe_n),
        .ftdi_rde_n     (rde_n),
        .ftdi_wr_n      (wr_n),
        .ftdi_rd_n      (rd_n),
        .ftdi_oe_n      (oe_n),
        .ftdi_siwu      (siwu),
        .ftdi_suspend_n (suspend_n)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] rd_src[$];
    logic [7:0] in_exp[$];
    logic [7:0] out_exp[$];
    int cyc = 0;
    int rd_xfers = 0;
    int wr_xfers = 0;
    int wr_low_edges = 0;
    int siwu_low = 0;
    int siwu_cyc = -1;
    int last_rd_cyc = -1;
    int first_wr_cyc = -1;
    int last_wr_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // FT245 chip model: sample strobes at negedge, complete transfers after the posedge.
    always begin : ft_model
        logic       rx, wx, wl;
        logic [7:0] wb;
        @(negedge clk);
        rx = (rd_n == 1'b0) && (rde_n == 1'b0);
        wx = (wr_n == 1'b0) && (txe_n == 1'b0);
        wl = (wr_n == 1'b0);
        wb = ftdi_data;
        if (siwu == 1'b0) begin
            siwu_low++;
            siwu_cyc = cyc;
        end
        if (oe_n == 1'b0 && wr_n == 1'b0) check("oe_wr_overlap", 1, 0);
        @(posedge clk);
        cyc++;
        #1;
        if (wl) wr_low_edges++;
        if (rx && rd_src.size() > 0) begin
            void'(rd_src.pop_front());
            rd_xfers++;
            last_rd_cyc = cyc;
        end
        if (wx) begin
            wr_xfers++;
            last_wr_cyc = cyc;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (out_exp.size() == 0) check("wr_extra", 1, 0);
            else check("wr_byte", {24'h0, wb}, {24'h0, out_exp.pop_front()});
        end
        #1;
        rde_n   = (rd_src.size() == 0);
        bus_drv = (rd_src.size() > 0) ? rd_src[0] : 8'h00;
    end

    task automatic load_rd(input logic [7:0] b, input bit track);
        rd_src.push_back(b);
        if (track) in_exp.push_back(b);
    endtask

    task automatic push_out(input logic [7:0] b);
        check("full_before_push", {31'h0, out_fifo_full}, 0);
        out_fifo_wr   = 1'b1;
        out_fifo_data = b;
        out_exp.push_back(b);
        @(posedge clk); #1;
        out_fifo_wr = 1'b0;
    endtask

    // Pop n bytes, driving in_fifo_rd at negedge so no extra pop slips through.
    task automatic drain(input int n, input int budget, input string tag);
        int   issued = 0;
        int   got = 0;
        int   c = 0;
        logic pend = 1'b0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (pend) begin
                got++;
                if (in_exp.size() == 0) check({tag, "_noexp"}, 1, 0);
                else check(tag, {24'h0, in_fifo_data}, {24'h0, in_exp.pop_front()});
            end
            pend       = (issued < n) && !in_fifo_empty;
            in_fifo_rd = pend;
            if (pend) issued++;
        end
        in_fifo_rd = 1'b0;
        if (got < n) check({tag, "_timeout"}, got, n);
    endtask

    task automatic wait_rd_xfers(input int target, input int budget, input string tag);
        int c = 0;
        while (rd_xfers < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (rd_xfers < target) check(tag, rd_xfers, target);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] t1 [5];
        int c;
        t1 = '{8'hCD, 8'h00, 8'h00, 8'h00, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_n", {31'h0, rd_n}, 1);
        check("rst_wr_n", {31'h0, wr_n}, 1);
        check("rst_oe_n", {31'h0, oe_n}, 1);
        check("rst_siwu", {31'h0, siwu}, 1);
        check("rst_in_data", {24'h0, in_fifo_data}, 0);
        check("rst_in_empty", {31'h0, in_fifo_empty}, 1);
        check("rst_out_full", {31'h0, out_fifo_full}, 0);
        check("rst_state", {29'h0, dut.state_reg}, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Read burst of five bytes
        for (int i = 0; i < 5; i++) load_rd(t1[i], 1'b1);
        c = 0;
        do begin @(negedge clk); c++; end while (oe_n != 1'b0 && c < 50);
        check("oe_seen", {31'h0, oe_n}, 0);
        check("rd_high_with_oe", {31'h0, rd_n}, 1);
        @(negedge clk);
        check("rd_low_after_oe", {31'h0, rd_n}, 0);
        repeat (15) @(negedge clk);
        check("in_count5", 32'(dut.in_count), 5);
        drain(5, 40, "pop5");
        check("empty_after_pop5", {31'h0, in_fifo_empty}, 1);

        // Four-byte write burst
        @(posedge clk); #1;
        txe_n = 1'b0;
        wr_low_edges = 0; wr_xfers = 0; siwu_low = 0;
        push_out(8'hDC); push_out(8'h01); push_out(8'h02); push_out(8'h03);
        repeat (20) @(negedge clk);
        check("wr_low_edges4", wr_low_edges, 4);
        check("wr_xfers4", wr_xfers, 4);
        check("out_exp_empty", out_exp.size(), 0);
        check("out_count0", 32'(dut.out_count), 0);
        check("state_idle_after_wr", {29'h0, dut.state_reg}, IDLE);
        check("siwu_after_burst", siwu_low, SIWU_PULSE);

        // TXE# raised after two accepted bytes
        @(posedge clk); #1;
        txe_n = 1'b1;
        wr_xfers = 0;
        push_out(8'h10); push_out(8'h11); push_out(8'h12); push_out(8'h13);
        txe_n = 1'b0;
        c = 0;
        while (wr_xfers < 2 && c < 50) begin @(negedge clk); c++; end
        txe_n = 1'b1;
        repeat (10) @(negedge clk);
        check("txe_pause_wr_n", {31'h0, wr_n}, 1);
        check("txe_pause_xfers", wr_xfers, 2);
        check("txe_pause_count", 32'(dut.out_count), 2);
        @(posedge clk); #1;
        txe_n = 1'b0;
        repeat (20) @(negedge clk);
        check("txe_resume_xfers", wr_xfers, 4);
        check("txe_resume_empty", out_exp.size(), 0);

        // Read and write pending together: read wins
        @(posedge clk); #1;
        txe_n = 1'b1;
        push_out(8'h20); push_out(8'h21);
        last_rd_cyc = -1; first_wr_cyc = -1;
        load_rd(8'h30, 1'b1); load_rd(8'h31, 1'b1); load_rd(8'h32, 1'b1);
        txe_n = 1'b0;
        repeat (40) @(negedge clk);
        check("prio_rd_seen", {31'h0, (last_rd_cyc > 0)}, 1);
        check("prio_rd_then_turn_then_wr", {31'h0, (first_wr_cyc > last_rd_cyc + 2)}, 1);
        check("prio_wr_done", out_exp.size(), 0);
        drain(3, 40, "pop_prio");

        // Flush during a read burst
        @(posedge clk); #1;
        c = rd_xfers;
        for (int i = 0; i < 20; i++) load_rd(8'(8'h40 + i), 1'b0);
        wait_rd_xfers(c + 3, 50, "flush_wait");
        in_fifo_rst = 1'b1;
        @(posedge clk); #1;
        in_fifo_rst = 1'b0;
        rd_src.delete();
        @(negedge clk);
        check("flush_empty", {31'h0, in_fifo_empty}, 1);
        check("flush_count", 32'(dut.in_count), 0);
        repeat (10) @(negedge clk);
        check("flush_rd_n", {31'h0, rd_n}, 1);
        check("flush_oe_n", {31'h0, oe_n}, 1);
        check("flush_still_empty", {31'h0, in_fifo_empty}, 1);

        // Suspend holds off reads
        @(posedge clk); #1;
        suspend_n = 1'b0;
        load_rd(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        check("susp_oe_n", {31'h0, oe_n}, 1);
        check("susp_empty", {31'h0, in_fifo_empty}, 1);
        @(posedge clk); #1;
        suspend_n = 1'b1;
        repeat (10) @(negedge clk);
        drain(1, 20, "pop_susp");

        // 600-byte stream with no pops stops at 510 stored
        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) load_rd(8'((i * 7 + 3) & 8'hFF), 1'b1);
        c = 0;
        while (rd_src.size() > 90 && c < 800) begin @(negedge clk); c++; end
        repeat (10) @(negedge clk);
        check("fill_count510", 32'(dut.in_count), 510);
        check("fill_src_left90", rd_src.size(), 90);
        check("fill_rd_n", {31'h0, rd_n}, 1);
        check("fill_oe_n", {31'h0, oe_n}, 1);
        drain(600, 4000, "pop600");
        check("empty_after_600", {31'h0, in_fifo_empty}, 1);

        // Single-byte write and SIWU
        @(posedge clk); #1;
        siwu_low = 0; siwu_cyc = -1; wr_xfers = 0;
        txe_n = 1'b0;
        push_out(8'h77);
        repeat (15) @(negedge clk);
        check("single_wr_xfer", wr_xfers, 1);
        check("single_siwu_pulses", siwu_low, SIWU_PULSE);
`ifdef FT245_SIWU_FLUSH_EN
        check("single_siwu_after_accept", siwu_cyc, last_wr_cyc);
`endif

        // Reset in the middle of a read burst
        @(posedge clk); #1;
        c = rd_xfers;
        for (int i = 0; i < 30; i++) load_rd(8'(8'h90 + i), 1'b0);
        wait_rd_xfers(c + 3, 50, "rst_wait");
        rst_n = 1'b0;
        #1;
        check("midrst_rd_n", {31'h0, rd_n}, 1);
        check("midrst_oe_n", {31'h0, oe_n}, 1);
        check("midrst_wr_n", {31'h0, wr_n}, 1);
        check("midrst_empty", {31'h0, in_fifo_empty}, 1);
        check("midrst_count", 32'(dut.in_count), 0);
        rd_src.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_state", {29'h0, dut.state_reg}, IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft245_sync_fifo_core.md
FT245_SYNC_FIFO_CORE -- requirements
Module: ft245_sync_fifo_core

Interface
REQ-001 SHALL have parameter FIFO_AW, default 9, meaning log2 of depth in bytes for each internal FIFO (512 bytes).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, which is the FT245 CLKOUT (60 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_fifo_rst, input, 1 bit: synchronous flush of the host-to-FPGA FIFO.
REQ-005 SHALL have port in_fifo_rd, input, 1 bit: pop one byte from the host-to-FPGA FIFO.
REQ-006 SHALL have port in_fifo_empty, output, 1 bit: host-to-FPGA FIFO holds no bytes.
REQ-007 SHALL have port in_fifo_data, output, 8 bits: the popped byte, registered.
REQ-008 SHALL have port out_fifo_wr, input, 1 bit: push out_fifo_data into the FPGA-to-host FIFO.
REQ-009 SHALL have port out_fifo_full, output, 1 bit: FPGA-to-host FIFO is full.
REQ-010 SHALL have port out_fifo_data, input, 8 bits: byte to push.
REQ-011 SHALL have port ftdi_data, inout, 8 bits: FT245 D[7:0].
REQ-012 SHALL have ports ftdi_txe_n and ftdi_rde_n, inputs, 1 bit each: TXE# and RXF#.
REQ-013 SHALL have ports ftdi_wr_n, ftdi_rd_n, ftdi_oe_n and ftdi_siwu, outputs, 1 bit each: WR#, RD#, OE# and SIWU (all registered).
REQ-014 SHALL have port ftdi_suspend_n, input, 1 bit: SUSPEND#.

Function
REQ-015 SHALL update in_fifo_data on the edge after a pop is accepted (1-cycle latency) and hold it otherwise; in_fifo_rd while empty is ignored.
REQ-016 SHALL ignore out_fifo_wr while full; in_fifo_empty and out_fifo_full SHALL be combinational from the occupancy counts.
REQ-017 SHALL, on in_fifo_rst, zero the in-FIFO pointers and count in one cycle, and any byte captured from the bus in that cycle SHALL be dropped.
REQ-018 SHALL implement FSM states IDLE, READ_OE, READ, WRITE, TURN.
REQ-019 IDLE: ftdi_suspend_n low -> stay; else if rde_n low and in-FIFO free space > 2 -> READ_OE with oe_n<=0; else if txe_n low and out FIFO non-empty -> WRITE; reads have priority.
REQ-020 READ_OE: rd_n<=0 -> READ.
REQ-021 READ: capture ftdi_data into the in FIFO on every edge with rd_n=0 and rde_n=0.
REQ-022 READ exit: rde_n high, free space <= 2 (headroom for RD# registration), in_fifo_rst, or suspend_n low -> rd_n<=1, oe_n<=1, go to TURN.
REQ-023 WRITE: drive ftdi_data with the out-FIFO head (first-word fall-through); a byte is accepted and popped on an edge with wr_n=0 and txe_n=0.
REQ-024 WRITE: wr_n<=0 only if, after this edge's pop, at least one byte remains and txe_n=0; no byte is ever written twice or stale.
REQ-025 WRITE exit: out FIFO empty after pop, txe_n high, or suspend_n low -> wr_n<=1, go to TURN.
REQ-026 TURN: one cycle with the bus released -> IDLE.
REQ-027 ftdi_data SHALL be driven only in WRITE; oe_n=0 and bus drive SHALL never overlap.
REQ-028 Simultaneous user push/pop and bus pop/push on the same FIFO in one cycle SHALL both take effect with the count unchanged.

Reset
REQ-029 On reset: rd_n=wr_n=oe_n=siwu=1, bus tri-stated, in_fifo_data=0, in_fifo_empty=1, out_fifo_full=0, both FIFOs empty, FSM=IDLE.
REQ-030 Reset asserted mid-burst SHALL immediately deassert all strobes and discard FIFO contents.

Configuration
REQ-031 SHALL support macro FT245_SIWU_FLUSH_EN: when defined, pulse ftdi_siwu low for one cycle when WRITE exits with the out FIFO empty; when undefined, ftdi_siwu is constant 1.

Structure
REQ-032 Package ft245_sync_pkg SHALL hold the FSM state enum and the read-headroom constant (2).
REQ-033 Sub-module byte_fifo (single-clock, FWFT, parameter FIFO_AW, with count output) SHALL be instantiated twice.

Verification
REQ-034 Reset, then bench drives rde_n low with 0xCD,0x00,0x00,0x00,0x01 -> oe_n low one cycle before rd_n; 5 bytes in FIFO; popped values in order, each 1 cycle after in_fifo_rd.
REQ-035 Push 0xDC,0x01,0x02,0x03 with txe_n low -> exactly 4 wr_n-low edges, bus bytes in order, out FIFO empty, TURN then IDLE.
REQ-036 txe_n raised mid-write after 2 accepted bytes -> wr_n high, remaining 2 bytes sent in order after txe_n returns low, no duplicate.
REQ-037 Stream 600 bytes with no pops -> reading stops at 510 stored, rd_n high, no byte lost or overwritten.
REQ-038 Pending read and write together -> read burst first, then TURN, then WRITE; in_fifo_rst during a read -> in_fifo_empty=1 next cycle.
REQ-039 With FT245_SIWU_FLUSH_EN defined, a single-byte write -> one-cycle siwu low pulse after the byte is accepted.
